// File: rtl/cancel_pkg.sv
// Shared types for the cancel-ack feeder: entry layout, issue FSM states and
// the saturating adder used when CANCEL_COALESCE_EN merges same-client acks.
package cancel_pkg;

  localparam int CANCEL_CLIENT_W = 5;
  localparam int CANCEL_AMT_W    = 32;

  typedef struct packed {
    logic [CANCEL_CLIENT_W-1:0] client_id;
    logic [CANCEL_AMT_W-1:0]    amount;
  } cancel_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } feeder_state_e;

  function automatic logic [CANCEL_AMT_W-1:0] sat_add(
    input logic [CANCEL_AMT_W-1:0] a,
    input logic [CANCEL_AMT_W-1:0] b
  );
    logic [CANCEL_AMT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CANCEL_AMT_W] ? {CANCEL_AMT_W{1'b1}} : sum[CANCEL_AMT_W-1:0];
  endfunction

endpackage

// File: rtl/cancel_fifo.sv
// Synchronous FIFO of cancel entries with wrap-bit pointers. When
// CANCEL_COALESCE_EN is defined it also exposes a tail read/rewrite port.
module cancel_fifo
  import cancel_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef CANCEL_COALESCE_EN
  input  logic                    i_tail_wr,
  input  logic [CANCEL_AMT_W-1:0] i_tail_amount,
  output cancel_entry_t           o_tail,
  output logic                    o_single,
`endif
  input  logic                    i_push,
  input  cancel_entry_t           i_push_data,
  input  logic                    i_pop,
  output cancel_entry_t           o_head,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cancel_entry_t r_mem [DEPTH];
  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign o_head   = r_mem[w_rd_idx];
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_count  = r_count;

`ifdef CANCEL_COALESCE_EN
  logic [AW-1:0] w_tail_idx;
  assign w_tail_idx = w_wr_idx - AW'(1);
  assign o_tail     = r_mem[w_tail_idx];
  assign o_single   = (r_count == CW'(1));
`endif

  // Pointer and fill-level bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= CW'(0);
      r_rd_ptr <= CW'(0);
      r_count  <= CW'(0);
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; a merge only rewrites the amount of the tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {$bits(cancel_entry_t){1'b0}};
    end else if (i_push) begin
      r_mem[w_wr_idx] <= i_push_data;
`ifdef CANCEL_COALESCE_EN
    end else if (i_tail_wr) begin
      r_mem[w_tail_idx].amount <= i_tail_amount;
`endif
    end
  end

endmodule

// File: rtl/cancel_ack_feeder.sv
// Filters and buffers exchange cancel acks, then issues one registered update
// per cycle with a bubble between same-client updates. Optional CANCEL_COALESCE_EN.
module cancel_ack_feeder
  import cancel_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int CLIENT_W = CANCEL_CLIENT_W,
  parameter int AMT_W    = CANCEL_AMT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CLIENT_W-1:0]    in_client_id,
  input  logic [AMT_W-1:0]       in_amount,
  input  logic                   in_reject,
  output logic                   ack,
  output logic [CLIENT_W-1:0]    client_id,
  output logic [AMT_W-1:0]       amount,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            drop_cnt
);

  cancel_entry_t w_in_entry;
  cancel_entry_t w_head;
  feeder_state_e r_state;
  feeder_state_e w_next_state;
  logic w_accept;
  logic w_drop;
  logic w_store;
  logic w_merge;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_full;
  logic r_ack;
  logic r_last_valid;
  logic [CLIENT_W-1:0] r_client_id;
  logic [AMT_W-1:0]    r_amount;
  logic [15:0]         r_drop_cnt;

  assign w_in_entry = '{client_id: in_client_id, amount: in_amount};
  assign in_ready   = !w_full;
  assign w_accept   = in_valid && in_ready;
  assign w_drop     = w_accept && (in_reject || (in_amount == {AMT_W{1'b0}}));
  assign w_store    = w_accept && !w_drop;
  assign w_push     = w_store && !w_merge;

`ifdef CANCEL_COALESCE_EN
  cancel_entry_t     w_tail;
  logic              w_single;
  logic [AMT_W-1:0]  w_tail_amount;
  // The tail may only absorb the new ack if it is not leaving this cycle.
  assign w_merge       = w_store && !w_empty && (w_tail.client_id == in_client_id)
                         && !(w_pop && w_single);
  assign w_tail_amount = sat_add(w_tail.amount, in_amount);
`else
  assign w_merge = 1'b0;
`endif

  cancel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef CANCEL_COALESCE_EN
    .i_tail_wr    (w_merge),
    .i_tail_amount(w_tail_amount),
    .o_tail       (w_tail),
    .o_single     (w_single),
`endif
    .i_push       (w_push),
    .i_push_data  (w_in_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_count      (occupancy)
  );

  // Issue FSM: an entry is popped on every edge that enters ISSUE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_next_state = ST_ISSUE;
        else          w_next_state = ST_IDLE;
      end
      ST_ISSUE: begin
        if (w_empty)                                              w_next_state = ST_IDLE;
        else if (r_last_valid && (w_head.client_id == r_client_id)) w_next_state = ST_GAP;
        else                                                      w_next_state = ST_ISSUE;
      end
      ST_GAP: begin
        if (w_empty) w_next_state = ST_IDLE;
        else         w_next_state = ST_ISSUE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    w_pop = (w_next_state == ST_ISSUE);
  end

  // State, update strobe, held update payload and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ack        <= 1'b0;
      r_last_valid <= 1'b0;
      r_client_id  <= {CLIENT_W{1'b0}};
      r_amount     <= {AMT_W{1'b0}};
      r_drop_cnt   <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      r_ack   <= w_pop;
      if (w_pop) begin
        r_client_id  <= w_head.client_id;
        r_amount     <= w_head.amount;
        r_last_valid <= 1'b1;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign ack       = r_ack;
  assign client_id = r_client_id;
  assign amount    = r_amount;
  assign drop_cnt  = r_drop_cnt;

endmodule
